bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential double-dabble converter that turns the ALU's binary result into packed BCD digits before the result reaches the 4-digit display multiplexer. It sits between the ALU output and the display control stage, so the two result digit positions show decimal values (00–63) instead of raw nibbles. Each conversion is launched by a one-cycle Start request and completes in a fixed number of cycles, signalled by a one-cycle Done pulse. Bcd holds its last completed value between conversions.

## Interface
- WIDTH, 6: binary input width; also the number of shift iterations.
- DIGITS, 2: number of BCD output digits; packed output width is 4*DIGITS.
- ClockA  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  reset, synchronous, active-high.
- Start  input  1  conversion request; sampled only in IDLE.
- Binary  input  WIDTH  unsigned value to convert; sampled on the accepting edge only.
- Bcd  output  4*DIGITS  packed BCD result; [3:0] ones, [7:4] tens, and so on. Registered.
- Overflow  output  1  the last completed value did not fit in DIGITS digits. Registered, updates with Bcd.
- Busy  output  1  high while a conversion is in progress (SHIFT and DONE states).
- Done  output  1  one-cycle pulse: Bcd and Overflow are updated and valid.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - If Start=1: load shift register ← Binary, clear scratch BCD register (4*DIGITS bits), clear iteration counter, clear sticky overflow, go to SHIFT.
  - If Start=0: stay in IDLE.
- SHIFT, one iteration per edge:
  - Add 3 to every scratch digit that is ≥5.
  - Shift {scratch, shift register} left by 1.
  - If the bit shifted out of the scratch MSB is 1, set sticky overflow.
  - Increment the counter.
  - On the iteration where the counter reaches WIDTH-1: write the post-shift scratch to Bcd, write sticky overflow (including this iteration's carry-out) to Overflow, assert Done, go to DONE.
- DONE: deassert Done and Busy, go to IDLE.
- Start is ignored in SHIFT and DONE; requests are not queued. Binary changes after the accepting edge have no effect.
- Overflow is set only when the value ≥ 10^DIGITS. In that case Bcd = value mod 10^DIGITS, which the truncated double-dabble produces naturally.
- Counter width is clog2(WIDTH+1).
- All adds are 4-bit per digit with no inter-digit carry. The adjust operation never produces a nibble above 12 before the shift.
- Reset (any state, including mid-conversion): state IDLE, Bcd=0, Overflow=0, Busy=0, Done=0, counter=0, scratch=0. An aborted conversion never asserts Done, and Bcd stays 0.
- Reset has priority over Start on the same edge.

## Timing
- Edge k accepts Start: Busy=1 from after edge k.
- Edges k+1 … k+WIDTH perform the WIDTH iterations. Bcd, Overflow and Done=1 are visible after edge k+WIDTH.
- After edge k+WIDTH+1: Done=0, Busy=0, state IDLE.
- Earliest next accepting edge is k+WIDTH+2.
- Start-to-Done latency is WIDTH cycles (6 at defaults). Throughput is one conversion per WIDTH+2 cycles.
- Done is high for exactly one cycle per completed conversion.
- Bcd changes only on the Done edge or on Reset.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then Binary=0, Start for 1 cycle -> Done after exactly 6 cycles; Bcd=8'h00, Overflow=0, Busy high for 7 cycles total.
- Binary=63 -> Bcd=8'h63, Overflow=0. Binary=9 -> 8'h09. Binary=10 -> 8'h10. Sweep all 0..63 and compare against a decimal model: every result matches, exactly one Done per Start.
- Start held high continuously with Binary=5, then changing to 42 during SHIFT -> first result 8'h05 at edge k+6. The next acceptance is at edge k+8, with Start still high, and that conversion uses the Binary value present at edge k+8 (42 → 8'h42). Start pulses during SHIFT/DONE produce no extra Done.
- Assert Reset at the third SHIFT iteration of a conversion of 37, after a prior result of 8'h21 -> the edge after Reset gives Bcd=0, Overflow=0, Busy=0, Done=0. No Done follows; a fresh Start of 37 then yields 8'h37.
- Parameters WIDTH=6, DIGITS=1, Binary=10 -> Overflow=1, Bcd=4'h0. Binary=57 -> Overflow=1, Bcd=4'h7. Binary=9 -> Overflow=0, Bcd=4'h9.
- Reset and Start asserted on the same edge -> stays IDLE, Busy=0, and no Done ever follows.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift iteration per clock,
// start-to-done latency of WIDTH cycles, result held in Bcd until the next Done.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 2
) (
   input  logic                  ClockA,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [WIDTH-1:0]      Binary,
   output logic [4*DIGITS-1:0]   Bcd,
   output logic                  Overflow,
   output logic                  Busy,
   output logic                  Done
);
   localparam int BW = 4*DIGITS;
   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]   scratch;
   logic [BW-1:0]   adj;
   logic [BW-1:0]   nxt_scr;
   logic [CW-1:0]   cnt;
   logic            sticky;
   logic            cout;

   // Per-digit add-3 adjust; digits are independent, no carry between them.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      assign adj[4*g +: 4] = (scratch[4*g +: 4] >= 4'd5) ? scratch[4*g +: 4] + 4'd3
                                                          : scratch[4*g +: 4];
   end

   assign cout    = adj[BW-1];
   assign nxt_scr = {adj[BW-2:0], shreg[WIDTH-1]};

   always_ff @(posedge ClockA) begin
      if (Reset) begin
         state    <= IDLE;
         shreg    <= '0;
         scratch  <= '0;
         cnt      <= '0;
         sticky   <= 1'b0;
         Bcd      <= '0;
         Overflow <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  shreg   <= Binary;
                  scratch <= '0;
                  cnt     <= '0;
                  sticky  <= 1'b0;
                  Busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= nxt_scr;
               shreg   <= {shreg[WIDTH-2:0], 1'b0};
               sticky  <= sticky | cout;
               cnt     <= cnt + CW'(1);
               // Last iteration: publish the post-shift result, including this carry-out.
               if (cnt == CW'(WIDTH-1)) begin
                  Bcd      <= nxt_scr;
                  Overflow <= sticky | cout;
                  Done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 2-digit instance plus a 1-digit
// instance sharing the same stimulus for the overflow cases.
module tb_bin_to_bcd_seq;
   logic       ClockA = 1'b0;
   logic       Reset  = 1'b1;
   logic       Start  = 1'b0;
   logic [5:0] Binary = '0;
   logic [7:0] Bcd;
   logic       Overflow, Busy, Done;
   logic [3:0] Bcd1;
   logic       Overflow1, Busy1, Done1;

   int checks = 0;
   int errors = 0;

   bin_to_bcd_seq #(.WIDTH(6), .DIGITS(2)) dut (
      .ClockA(ClockA), .Reset(Reset), .Start(Start), .Binary(Binary),
      .Bcd(Bcd), .Overflow(Overflow), .Busy(Busy), .Done(Done));

   bin_to_bcd_seq #(.WIDTH(6), .DIGITS(1)) dut1 (
      .ClockA(ClockA), .Reset(Reset), .Start(Start), .Binary(Binary),
      .Bcd(Bcd1), .Overflow(Overflow1), .Busy(Busy1), .Done(Done1));

   always #5 ClockA = ~ClockA;

   task automatic tick();
      @(posedge ClockA);
      #1;
   endtask

   // Runs one conversion; samples after the accepting edge (i=0) and nine more edges.
   task automatic do_conv(input logic [5:0] v, output logic [7:0] bcd, output logic ovf,
                          output logic [3:0] bcd1, output logic ovf1,
                          output int lat, output int busyc, output int donec);
      bcd = 'x; ovf = 'x; bcd1 = 'x; ovf1 = 'x; lat = -1; busyc = 0; donec = 0;
      Start = 1'b1; Binary = v;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         if (Busy) busyc++;
         if (Done) begin
            donec++;
            lat  = i;
            bcd  = Bcd;
            ovf  = Overflow;
            bcd1 = Bcd1;
            ovf1 = Overflow1;
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      checks++;
      if ({Bcd, Overflow, Busy, Done} !== 11'h0) begin
         errors++;
         $display("FAIL reset_state got bcd=%h ovf=%b busy=%b done=%b exp all 0", Bcd, Overflow, Busy, Done);
      end
   endtask

   task automatic test_zero();
      logic [7:0] b; logic o; logic [3:0] b1; logic o1; int lat, bc, dc;
      do_conv(6'd0, b, o, b1, o1, lat, bc, dc);
      checks++;
      if (lat !== 6 || dc !== 1) begin
         errors++;
         $display("FAIL zero_latency got lat=%0d dones=%0d exp lat=6 dones=1", lat, dc);
      end
      checks++;
      if (bc !== 7) begin
         errors++;
         $display("FAIL zero_busy got %0d exp 7", bc);
      end
      checks++;
      if (b !== 8'h00 || o !== 1'b0) begin
         errors++;
         $display("FAIL zero_value got %h ovf=%b exp 00 ovf=0", b, o);
      end
   endtask

   task automatic test_directed();
      logic [5:0] vin [3] = '{6'd63, 6'd9, 6'd10};
      logic [7:0] vexp[3] = '{8'h63, 8'h09, 8'h10};
      logic [7:0] b; logic o; logic [3:0] b1; logic o1; int lat, bc, dc;
      for (int i = 0; i < 3; i++) begin
         do_conv(vin[i], b, o, b1, o1, lat, bc, dc);
         checks++;
         if (b !== vexp[i] || o !== 1'b0 || dc !== 1) begin
            errors++;
            $display("FAIL directed_%0d got %h ovf=%b dones=%0d exp %h ovf=0 dones=1",
                     vin[i], b, o, dc, vexp[i]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [7:0] b, e; logic o; logic [3:0] b1; logic o1; int lat, bc, dc;
      for (int v = 0; v < 64; v++) begin
         do_conv(6'(v), b, o, b1, o1, lat, bc, dc);
         e = 8'(((v / 10) << 4) | (v % 10));
         checks++;
         if (b !== e || o !== 1'b0 || dc !== 1 || lat !== 6) begin
            errors++;
            $display("FAIL sweep_%0d got %h ovf=%b dones=%0d lat=%0d exp %h ovf=0 dones=1 lat=6",
                     v, b, o, dc, lat, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      int dc = 0;
      logic [7:0] r0 = 'x, r1 = 'x;
      int t0 = -1, t1 = -1;
      logic busy7 = 'x, busy8 = 'x;
      Start = 1'b1; Binary = 6'd5;
      tick();  // edge k
      for (int i = 0; i < 20; i++) begin
         if (i > 0) tick();
         if (i == 2) Binary = 6'd42;
         if (i == 12) Start = 1'b0;
         if (i == 7) busy7 = Busy;
         if (i == 8) busy8 = Busy;
         if (Done) begin
            if (dc == 0) begin r0 = Bcd; t0 = i; end
            else if (dc == 1) begin r1 = Bcd; t1 = i; end
            dc++;
         end
      end
      checks++;
      if (r0 !== 8'h05 || t0 !== 6) begin
         errors++;
         $display("FAIL b2b_first got %h at %0d exp 05 at 6", r0, t0);
      end
      checks++;
      if (busy7 !== 1'b0 || busy8 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_reaccept got busy7=%b busy8=%b exp 0 1", busy7, busy8);
      end
      checks++;
      if (r1 !== 8'h42 || t1 !== 14 || dc !== 2) begin
         errors++;
         $display("FAIL b2b_second got %h at %0d dones=%0d exp 42 at 14 dones=2", r1, t1, dc);
      end
   endtask

   task automatic test_abort();
      logic [7:0] b; logic o; logic [3:0] b1; logic o1; int lat, bc, dc;
      int dn = 0;
      do_conv(6'd21, b, o, b1, o1, lat, bc, dc);
      checks++;
      if (b !== 8'h21) begin
         errors++;
         $display("FAIL abort_prior got %h exp 21", b);
      end
      Start = 1'b1; Binary = 6'd37;
      tick();            // accept
      Start = 1'b0;
      tick(); tick();    // two iterations
      Reset = 1'b1;
      tick();            // third iteration edge replaced by reset
      Reset = 1'b0;
      checks++;
      if ({Bcd, Overflow, Busy, Done} !== 11'h0) begin
         errors++;
         $display("FAIL abort_reset got bcd=%h ovf=%b busy=%b done=%b exp all 0", Bcd, Overflow, Busy, Done);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (Done) dn++;
      end
      checks++;
      if (dn !== 0 || Bcd !== 8'h00) begin
         errors++;
         $display("FAIL abort_nodone got dones=%0d bcd=%h exp 0 00", dn, Bcd);
      end
      do_conv(6'd37, b, o, b1, o1, lat, bc, dc);
      checks++;
      if (b !== 8'h37 || dc !== 1) begin
         errors++;
         $display("FAIL abort_restart got %h dones=%0d exp 37 dones=1", b, dc);
      end
   endtask

   task automatic test_digits1();
      logic [5:0] vin [3] = '{6'd10, 6'd57, 6'd9};
      logic [3:0] vexp[3] = '{4'h0, 4'h7, 4'h9};
      logic       oexp[3] = '{1'b1, 1'b1, 1'b0};
      logic [7:0] b; logic o; logic [3:0] b1; logic o1; int lat, bc, dc;
      for (int i = 0; i < 3; i++) begin
         do_conv(vin[i], b, o, b1, o1, lat, bc, dc);
         checks++;
         if (b1 !== vexp[i] || o1 !== oexp[i]) begin
            errors++;
            $display("FAIL digits1_%0d got %h ovf=%b exp %h ovf=%b", vin[i], b1, o1, vexp[i], oexp[i]);
         end
      end
   endtask

   task automatic test_reset_start();
      int dn = 0;
      Reset = 1'b1; Start = 1'b1; Binary = 6'd20;
      tick();
      Reset = 1'b0; Start = 1'b0;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("FAIL rst_start_idle got busy=%b done=%b exp 0 0", Busy, Done);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (Done || Busy) dn++;
      end
      checks++;
      if (dn !== 0) begin
         errors++;
         $display("FAIL rst_start_nodone got %0d active cycles exp 0", dn);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_directed();
      test_sweep();
      test_back_to_back();
      test_abort();
      test_digits1();
      test_reset_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
